// File: rtl/pc_trace_buffer.sv
// Program-counter trace unit: captures PC updates into a circular buffer,
// counts cycles and captures, and freezes the trace when the PC hangs.
module pc_trace_buffer #(
    parameter int PC_WIDTH    = 64,
    parameter int DEPTH       = 16,
    parameter int STALL_LIMIT = 8,
    parameter int OVERWRITE   = 1,
    parameter int CHANGE_ONLY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PC_WIDTH-1:0]      pc_in,
    input  logic                     pc_valid,
    input  logic                     rd_en,
    output logic [PC_WIDTH-1:0]      rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     stall_detect,
    output logic [31:0]              cycle_count,
    output logic [31:0]              change_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STALL_LIMIT);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]  STALL_MAX = SC_W'(STALL_LIMIT - 1);

    typedef enum logic {ST_RUN, ST_FROZEN} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PC_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic [PC_WIDTH-1:0]   last_pc_q, last_pc_d;
    logic                  last_valid_q, last_valid_d;
    logic [SC_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [31:0]           cycle_q, cycle_d, change_q, change_d;
    logic [PC_WIDTH-1:0]   mem_q [DEPTH];

    logic same_pc, capture, pop, is_full, wr_en;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        rd_data_d    = rd_data_q;
        overflow_d   = overflow_q;
        last_pc_d    = last_pc_q;
        last_valid_d = last_valid_q;
        stall_cnt_d  = stall_cnt_q;
        change_d     = change_q;
        cycle_d      = cycle_q + 32'd1;
        wr_en        = 1'b0;

        same_pc    = last_valid_q && (pc_in == last_pc_q);
        capture    = pc_valid && (state_q == ST_RUN) && ((CHANGE_ONLY == 0) || !same_pc);
        pop        = rd_en && (count_q != '0);
        is_full    = (count_q == DEPTH_C);
        rd_valid_d = pop;

        if (pop) begin
            rd_data_d = mem_q[rptr_q];
            rptr_d    = rptr_q + PTR_W'(1);
        end

        // A full buffer only loses data when no pop frees a slot this cycle.
        if (capture) begin
            change_d = change_q + 32'd1;
            if (is_full && !pop) begin
                overflow_d = 1'b1;
                if (OVERWRITE != 0) begin
                    wr_en  = 1'b1;
                    rptr_d = rptr_q + PTR_W'(1);
                end
            end else begin
                wr_en = 1'b1;
            end
        end

        if (wr_en) wptr_d = wptr_q + PTR_W'(1);

        if (wr_en && !pop && !is_full) count_d = count_q + CNT_W'(1);
        else if (pop && !wr_en)        count_d = count_q - CNT_W'(1);

        if (pc_valid && (state_q == ST_RUN)) begin
            last_pc_d    = pc_in;
            last_valid_d = 1'b1;
            if (same_pc) begin
                if (stall_cnt_q == STALL_MAX) state_d = ST_FROZEN;
                else                          stall_cnt_d = stall_cnt_q + SC_W'(1);
            end else begin
                stall_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            overflow_q   <= 1'b0;
            last_pc_q    <= '0;
            last_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
            cycle_q      <= '0;
            change_q     <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            overflow_q   <= overflow_d;
            last_pc_q    <= last_pc_d;
            last_valid_q <= last_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            cycle_q      <= cycle_d;
            change_q     <= change_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (rst && wr_en) mem_q[wptr_q] <= pc_in;
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign overflow     = overflow_q;
    assign stall_detect = (state_q == ST_FROZEN);
    assign cycle_count  = cycle_q;
    assign change_count = change_q;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Self-checking bench for pc_trace_buffer: a queue-based reference model predicts
// buffer contents, flags and counters; popped entries flow through an expected queue.
module tb_pc_trace_buffer;
    localparam int PC_W        = 64;
    localparam int DEPTH       = 16;
    localparam int STALL_LIMIT = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] pc_in;
    logic            pc_valid;
    logic            rd_en;
    logic [PC_W-1:0] rd_data;
    logic            rd_valid;
    logic [4:0]      count;
    logic            empty, full, overflow, stall_detect;
    logic [31:0]     cycle_count, change_count;

    always #5 clk = ~clk;

    pc_trace_buffer #(
        .PC_WIDTH(PC_W), .DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT),
        .OVERWRITE(1), .CHANGE_ONLY(1)
    ) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .empty(empty),
        .full(full), .overflow(overflow), .stall_detect(stall_detect),
        .cycle_count(cycle_count), .change_count(change_count)
    );

    int checks = 0;
    int errors = 0;

    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] model_q[$];
    logic [PC_W-1:0] m_last, m_rd;
    bit              m_lv, m_frozen, m_ovf;
    int              m_run;
    logic [31:0]     m_cyc, m_chg;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: update the model from the inputs about to be sampled, then check.
    task automatic step();
        bit pop_exp;
        bit cap;
        pop_exp = 1'b0;
        cap     = 1'b0;
        if (!rst) begin
            model_q.delete();
            exp_q.delete();
            m_last = '0; m_rd = '0; m_lv = 0; m_frozen = 0; m_ovf = 0;
            m_run = 0; m_cyc = '0; m_chg = '0;
        end else begin
            pop_exp = rd_en && (model_q.size() > 0);
            if (pc_valid && !m_frozen) begin
                cap = !m_lv || (pc_in != m_last);
                if (m_lv && pc_in == m_last) m_run++;
                else                         m_run = 1;
                if (m_run == STALL_LIMIT + 1) m_frozen = 1;
                m_last = pc_in;
                m_lv   = 1;
            end
            if (pop_exp) exp_q.push_back(model_q.pop_front());
            if (cap) begin
                m_chg++;
                if (model_q.size() == DEPTH) begin
                    m_ovf = 1;
                    void'(model_q.pop_front());
                end
                model_q.push_back(pc_in);
            end
            m_cyc++;
        end
        @(posedge clk);
        #1;
        if (pop_exp) m_rd = exp_q.pop_front();
        check_eq("rd_valid", rd_valid, pop_exp);
        check_eq("rd_data", rd_data, m_rd);
        check_eq("count", count, model_q.size());
        check_eq("empty", empty, model_q.size() == 0);
        check_eq("full", full, model_q.size() == DEPTH);
        check_eq("overflow", overflow, m_ovf);
        check_eq("stall_detect", stall_detect, m_frozen);
        check_eq("cycle_count", cycle_count, m_cyc);
        check_eq("change_count", change_count, m_chg);
    endtask

    task automatic drive(input bit v, input logic [PC_W-1:0] pc, input bit re);
        pc_valid = v;
        pc_in    = pc;
        rd_en    = re;
        step();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        for (int i = 0; i < cycles; i++) drive(0, '0, 0);
        rst = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 1);
    endtask

    initial begin
        rst = 1'b0; pc_in = '0; pc_valid = 1'b0; rd_en = 1'b0;

        // Reset and free-running cycle counter
        do_reset(3);
        for (int i = 0; i < 3; i++) drive(0, '0, 0);

        // Sequential PCs, then pop them back in order
        for (int i = 0; i < 4; i++) drive(1, 64'(4 * i), 0);
        check_eq("seq_count", count, 4);
        drain(4);
        check_eq("seq_empty", empty, 1);

        // Overflow with overwrite: 18 PCs into 16 slots
        for (int i = 0; i < 18; i++) drive(1, 64'(4 * i), 0);
        check_eq("ovf_flag", overflow, 1);
        drain(16);

        // Full buffer with simultaneous push and pop
        do_reset(1);
        for (int i = 0; i < 16; i++) drive(1, 64'(4 * i), 0);
        drive(1, 64'd100, 1);
        check_eq("fullpp_ovf", overflow, 0);
        check_eq("fullpp_count", count, 16);
        drain(16);
        check_eq("fullpp_last", rd_data, 100);

        // Hang: PC 40 held for 9 valid samples, then a new PC is ignored
        do_reset(2);
        for (int i = 0; i < 9; i++) drive(1, 64'd40, 0);
        check_eq("hang_flag", stall_detect, 1);
        drive(1, 64'd44, 0);
        check_eq("hang_frozen", count, 1);
        drain(2);

        // Hang with a pc_valid gap in the middle of the run
        do_reset(2);
        for (int i = 0; i < 4; i++) drive(1, 64'd40, 0);
        for (int i = 0; i < 3; i++) drive(0, 64'd40, 0);
        for (int i = 0; i < 4; i++) drive(1, 64'd40, 0);
        check_eq("gap_not_yet", stall_detect, 0);
        drive(1, 64'd40, 0);
        check_eq("gap_flag", stall_detect, 1);

        // Reset while a pop and a capture are both pending
        do_reset(1);
        for (int i = 0; i < 5; i++) drive(1, 64'(8 * i + 8), 0);
        rst = 1'b0;
        drive(1, 64'd500, 1);
        rst = 1'b1;
        check_eq("rstmid_count", count, 0);
        check_eq("rstmid_rv", rd_valid, 0);

        // Random traffic with repeats, overflows and occasional hangs
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 0) do_reset(1);
            drive($urandom_range(0, 3) != 0, 64'(4 * $urandom_range(0, 5)),
                  $urandom_range(0, 2) == 0);
        end
        drain(18);

        check_eq("exp_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
